// File: rtl/transpose_buffer_pp_pkg.sv
// Shared types and helpers for the ping-pong transpose buffer.
package transpose_buffer_pkg;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_sel_t;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic bank_sel_t other_bank(input bank_sel_t b);
    return (b == BANK_A) ? BANK_B : BANK_A;
  endfunction

endpackage

// File: rtl/transpose_buffer_pp_if.sv
// Row-in / column-out stream bundle of the transpose buffer.
interface transpose_buffer_pp_if
  import transpose_buffer_pkg::*;
#(
  parameter int WORD_WIDTH  = 16,
  parameter int FETCH_WIDTH = 4,
  parameter int NUM_ROWS    = 4
);
  localparam int COL_W = idx_width(FETCH_WIDTH);

  logic [FETCH_WIDTH*WORD_WIDTH-1:0] mem_data;
  logic                              mem_valid;
  logic                              mem_ready;
  logic [NUM_ROWS*WORD_WIDTH-1:0]    out_data;
  logic                              out_valid;
  logic                              out_ready;
  logic [COL_W-1:0]                  out_col;
  logic                              out_last;

  modport master (
    output mem_data, mem_valid, out_ready,
    input  mem_ready, out_data, out_valid, out_col, out_last
  );

  modport slave (
    input  mem_data, mem_valid, out_ready,
    output mem_ready, out_data, out_valid, out_col, out_last
  );

endinterface

// File: rtl/transpose_buffer_pp_bank.sv
// One tile bank: whole-row write port, whole-column combinational read port.
module transpose_buffer_bank
  import transpose_buffer_pkg::*;
#(
  parameter int WORD_WIDTH  = 16,
  parameter int FETCH_WIDTH = 4,
  parameter int NUM_ROWS    = 4
) (
  input  logic                              clk,
  input  logic                              we,
  input  logic [idx_width(NUM_ROWS)-1:0]    wr_row,
  input  logic [FETCH_WIDTH*WORD_WIDTH-1:0] wr_data,
  input  logic [idx_width(FETCH_WIDTH)-1:0] rd_col,
  output logic [NUM_ROWS*WORD_WIDTH-1:0]    rd_data
);

  // Storage is deliberately unreset; the full flags qualify its contents.
  logic [WORD_WIDTH-1:0] mem [NUM_ROWS][FETCH_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        mem[wr_row][i] <= wr_data[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      rd_data[r*WORD_WIDTH +: WORD_WIDTH] = mem[r][rd_col];
    end
  end

endmodule

// File: rtl/transpose_buffer_pp.sv
// Ping-pong transpose buffer: rows fill one bank while the other drains by column.
// Bank life cycle (only full[] is stored; the rest follows from the pointers):
//   state    | meaning
//   EMPTY    | !full, not being written or write pointer at row 0
//   FILLING  | !full, wr_sel points here with row_idx > 0
//   FULL     | full, rd_sel elsewhere or col_idx == 0
//   DRAINING | full, rd_sel points here with col_idx > 0
module transpose_buffer_pp
  import transpose_buffer_pkg::*;
#(
  parameter int WORD_WIDTH  = 16,
  parameter int FETCH_WIDTH = 4,
  parameter int NUM_ROWS    = 4
) (
  input logic                clk,
  input logic                rst_n,
  input logic                flush,
  transpose_buffer_pp_if.slave bus
);

  localparam int ROW_W = idx_width(NUM_ROWS);
  localparam int COL_W = idx_width(FETCH_WIDTH);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FETCH_WIDTH - 1);

  logic [1:0]       full;
  bank_sel_t        wr_sel;
  bank_sel_t        rd_sel;
  logic [ROW_W-1:0] row_idx;
  logic [COL_W-1:0] col_idx;

  logic wr_fire;
  logic rd_fire;
  logic we_a;
  logic we_b;
  logic [NUM_ROWS*WORD_WIDTH-1:0] col_a;
  logic [NUM_ROWS*WORD_WIDTH-1:0] col_b;

  assign bus.mem_ready = !full[wr_sel];
  assign bus.out_valid = full[rd_sel];
  assign bus.out_col   = col_idx;
  assign bus.out_last  = full[rd_sel] && (col_idx == COL_LAST);
  assign bus.out_data  = (rd_sel == BANK_B) ? col_b : col_a;

  assign wr_fire = bus.mem_valid && !full[wr_sel];
  assign rd_fire = full[rd_sel] && bus.out_ready;
  assign we_a    = wr_fire && !flush && (wr_sel == BANK_A);
  assign we_b    = wr_fire && !flush && (wr_sel == BANK_B);

  // Set and clear of full[] always target different banks, so both may fire together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= '0;
      wr_sel  <= BANK_A;
      rd_sel  <= BANK_A;
      row_idx <= '0;
      col_idx <= '0;
    end else if (flush) begin
      full    <= '0;
      wr_sel  <= BANK_A;
      rd_sel  <= BANK_A;
      row_idx <= '0;
      col_idx <= '0;
    end else begin
      if (wr_fire) begin
        if (row_idx == ROW_LAST) begin
          row_idx      <= '0;
          full[wr_sel] <= 1'b1;
          wr_sel       <= other_bank(wr_sel);
        end else begin
          row_idx <= row_idx + ROW_W'(1);
        end
      end
      if (rd_fire) begin
        if (col_idx == COL_LAST) begin
          col_idx      <= '0;
          full[rd_sel] <= 1'b0;
          rd_sel       <= other_bank(rd_sel);
        end else begin
          col_idx <= col_idx + COL_W'(1);
        end
      end
    end
  end

  transpose_buffer_bank #(
    .WORD_WIDTH (WORD_WIDTH),
    .FETCH_WIDTH(FETCH_WIDTH),
    .NUM_ROWS   (NUM_ROWS)
  ) u_bank_a (
    .clk    (clk),
    .we     (we_a),
    .wr_row (row_idx),
    .wr_data(bus.mem_data),
    .rd_col (col_idx),
    .rd_data(col_a)
  );

  transpose_buffer_bank #(
    .WORD_WIDTH (WORD_WIDTH),
    .FETCH_WIDTH(FETCH_WIDTH),
    .NUM_ROWS   (NUM_ROWS)
  ) u_bank_b (
    .clk    (clk),
    .we     (we_b),
    .wr_row (row_idx),
    .wr_data(bus.mem_data),
    .rd_col (col_idx),
    .rd_data(col_b)
  );

endmodule
